// File: rtl/meta_ram_pkg.sv
// Shared types and elaboration helpers for the metadata RAM.
// Holds the clear-FSM state enum and the address/mask width functions.
package meta_ram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   // Address bits needed to index n entries (n >= 2).
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Number of write-mask granules in an entry.
   function automatic int mask_w(input int w, input int g);
      return w / g;
   endfunction

endpackage

// File: rtl/meta_ram_clear_ctrl.sv
// Clear sequencer: walks every entry once after reset or flush.
// Ports: clock, reset (async high), flush in; busy, clr_we, clr_addr out.
module meta_ram_clear_ctrl
   import meta_ram_pkg::*;
#(
   parameter int DEPTH = 40,
   parameter int AW    = clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          flush,
   output logic          busy,
   output logic          clr_we,
   output logic [AW-1:0] clr_addr
);

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   state_t        state;
   logic [AW-1:0] count;

   // busy is a flop of its own so the top sees a clean registered flag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= CLEAR;
         count <= '0;
         busy  <= 1'b1;
      end else begin
         unique case (state)
            CLEAR: begin
               // flush is deliberately not looked at here
               if (count == LAST) begin
                  state <= READY;
                  count <= '0;
                  busy  <= 1'b0;
               end else begin
                  count <= count + 1'b1;
               end
            end
            READY: begin
               if (flush) begin
                  state <= CLEAR;
                  count <= '0;
                  busy  <= 1'b1;
               end
            end
         endcase
      end
   end

   assign clr_we   = busy;
   assign clr_addr = count;

endmodule

// File: rtl/meta_ram.sv
// Multi-read-port metadata RAM with masked writes and self-clearing.
// Ports: clock, reset, flush, R_en/R_addr, W_en/W_addr/W_mask/W_data in;
//        R_data, R_valid, busy, addr_err out.
module meta_ram
   import meta_ram_pkg::*;
#(
   parameter  int DEPTH  = 40,
   parameter  int WIDTH  = 240,
   parameter  int NREAD  = 1,
   parameter  int GRAN   = 8,
   parameter  int BYPASS = 1,
   localparam int AW     = clog2(DEPTH),
   localparam int MW     = mask_w(WIDTH, GRAN)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   flush,
   input  logic [NREAD-1:0]       R_en,
   input  logic [NREAD*AW-1:0]    R_addr,
   input  logic                   W_en,
   input  logic [AW-1:0]          W_addr,
   input  logic [MW-1:0]          W_mask,
   input  logic [WIDTH-1:0]       W_data,
   output logic [NREAD*WIDTH-1:0] R_data,
   output logic [NREAD-1:0]       R_valid,
   output logic                   busy,
   output logic                   addr_err
);

   // DEPTH widened by one bit so range checks never wrap.
   localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

   logic             clr_we;
   logic [AW-1:0]    clr_addr;
   logic             ready;
   logic             w_in;
   logic             wr_go;
   logic [WIDTH-1:0] wbits;
   logic [NREAD-1:0] r_bad;
   logic             err_next;

   logic [WIDTH-1:0] mem [DEPTH];

   meta_ram_clear_ctrl #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_clear (
      .clock    (clock),
      .reset    (reset),
      .flush    (flush),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   assign ready = ~busy;
   assign w_in  = {1'b0, W_addr} < DEPTH_W;

   // A flush in the same cycle wins over the write.
   assign wr_go = ready & W_en & w_in & ~flush;

   always_comb begin
      wbits = '0;
      for (int g = 0; g < MW; g++) begin
         wbits[g*GRAN +: GRAN] = {GRAN{W_mask[g]}};
      end
   end

   // Storage has no reset; the clear sequencer zeroes it instead.
   always_ff @(posedge clock) begin
      if (clr_we) begin
         mem[clr_addr] <= '0;
      end else if (wr_go) begin
         mem[W_addr] <= (mem[W_addr] & ~wbits)
                      | (W_data & wbits);
      end
   end

   for (genvar p = 0; p < NREAD; p++) begin : g_rd
      logic [AW-1:0]    addr;
      logic             in_rng;
      logic             go;
      logic [WIDTH-1:0] old;
      logic [WIDTH-1:0] fwd;
      logic             v_q;
      logic [WIDTH-1:0] d_q;

      assign addr     = R_addr[p*AW +: AW];
      assign in_rng   = {1'b0, addr} < DEPTH_W;
      assign go       = R_en[p] & ready & in_rng;
      assign r_bad[p] = R_en[p] & ready & ~in_rng;
      assign old      = mem[addr];

      if (BYPASS != 0) begin : g_fwd
         // Merge the in-flight write granule by granule.
         assign fwd = (wr_go && (W_addr == addr))
                    ? ((old & ~wbits) | (W_data & wbits))
                    : old;
      end else begin : g_old
         assign fwd = old;
      end

      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            v_q <= 1'b0;
            d_q <= '0;
         end else begin
            v_q <= go;
            if (go) d_q <= fwd;
         end
      end

      assign R_valid[p]              = v_q;
      assign R_data[p*WIDTH +: WIDTH] = d_q;
   end

   assign err_next = ready & ((W_en & ~w_in) | (|r_bad));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) addr_err <= 1'b0;
      else       addr_err <= err_next;
   end

endmodule

// File: tb/tb_meta_ram.sv
// Self-checking bench for meta_ram: two instances (forwarding on/off)
// share stimulus and are compared against an array-based model.
module tb_meta_ram;

   localparam int D  = 40;
   localparam int W  = 240;
   localparam int NR = 2;
   localparam int AW = 6;
   localparam int MW = 30;

   logic            clock;
   logic            reset;
   logic            flush;
   logic [NR-1:0]   R_en;
   logic [NR*AW-1:0] R_addr;
   logic            W_en;
   logic [AW-1:0]   W_addr;
   logic [MW-1:0]   W_mask;
   logic [W-1:0]    W_data;
   logic [NR*W-1:0] rd1, rd0;
   logic [NR-1:0]   rv1, rv0;
   logic            busy1, busy0, err1, err0;

   int errors = 0;
   int checks = 0;

   logic [W-1:0]  model [D];
   int            busy_left;
   logic [NR-1:0] exp_v;
   logic [W-1:0]  exp_d1 [NR];
   logic [W-1:0]  exp_d0 [NR];
   logic          exp_err;
   logic          exp_busy;

   meta_ram #(.DEPTH(D), .WIDTH(W), .NREAD(NR), .GRAN(8), .BYPASS(1)) dut1 (
      .clock(clock), .reset(reset), .flush(flush),
      .R_en(R_en), .R_addr(R_addr),
      .W_en(W_en), .W_addr(W_addr), .W_mask(W_mask), .W_data(W_data),
      .R_data(rd1), .R_valid(rv1), .busy(busy1), .addr_err(err1));

   meta_ram #(.DEPTH(D), .WIDTH(W), .NREAD(NR), .GRAN(8), .BYPASS(0)) dut0 (
      .clock(clock), .reset(reset), .flush(flush),
      .R_en(R_en), .R_addr(R_addr),
      .W_en(W_en), .W_addr(W_addr), .W_mask(W_mask), .W_data(W_data),
      .R_data(rd0), .R_valid(rv0), .busy(busy0), .addr_err(err0));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   function automatic logic [W-1:0] rnd240();
      logic [255:0] t;
      for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
      return t[W-1:0];
   endfunction

   function automatic logic [AW-1:0] pick();
      if ($urandom_range(0, 9) == 0) return AW'($urandom_range(36, 63));
      return AW'($urandom_range(0, 7));
   endfunction

   task automatic idle();
      flush = 0; R_en = '0; R_addr = '0;
      W_en = 0; W_addr = '0; W_mask = '0; W_data = '0;
   endtask

   // Model: predict this cycle's results from the rules, then clock.
   task automatic tick();
      logic         rdy;
      logic [W-1:0] m;
      int           a;
      rdy = (busy_left == 0);
      for (int g = 0; g < MW; g++) m[g*8 +: 8] = {8{W_mask[g]}};
      exp_err = rdy && W_en && (int'(W_addr) >= D);
      for (int p = 0; p < NR; p++) begin
         a = int'(R_addr[p*AW +: AW]);
         exp_v[p] = 1'b0;
         if (rdy && R_en[p]) begin
            if (a < D) begin
               exp_v[p]  = 1'b1;
               exp_d0[p] = model[a];
               exp_d1[p] = model[a];
               if (W_en && !flush && int'(W_addr) == a)
                  exp_d1[p] = (model[a] & ~m) | (W_data & m);
            end else begin
               exp_err = 1'b1;
            end
         end
      end
      if (rdy && W_en && !flush && int'(W_addr) < D)
         model[W_addr] = (model[W_addr] & ~m) | (W_data & m);
      if (rdy && flush) begin
         for (int i = 0; i < D; i++) model[i] = '0;
         busy_left = D;
      end else if (busy_left > 0) begin
         busy_left--;
      end
      @(posedge clock);
      #1;
      exp_busy = (busy_left > 0);
   endtask

   task automatic do_reset();
      idle();
      reset = 1;
      #1;
      checks++;
      if (busy1 !== 1'b1 || rv1 !== '0 || err1 !== 1'b0 || rd1 !== '0) begin
         errors++;
         $display("FAIL reset_async1: got busy=%b v=%b err=%b want 1 00 0",
                  busy1, rv1, err1);
      end
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if (busy0 !== 1'b1 || rv0 !== '0 || err0 !== 1'b0 || rd0 !== '0) begin
         errors++;
         $display("FAIL reset_hold0: got busy=%b v=%b err=%b want 1 00 0",
                  busy0, rv0, err0);
      end
      reset = 0;
      busy_left = D;
      for (int i = 0; i < D; i++) model[i] = '0;
      exp_v = '0;
      for (int p = 0; p < NR; p++) begin
         exp_d1[p] = '0;
         exp_d0[p] = '0;
      end
   endtask

   task automatic test_reset();
      int n;
      do_reset();
      n = 0;
      while (busy1 && n < 100) begin
         n++;
         tick();
      end
      checks++;
      if (n !== D) begin
         errors++;
         $display("FAIL reset_busy_len: got %0d want %0d", n, D);
      end
      checks++;
      if (busy0 !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy0: got %b want 0", busy0);
      end
   endtask

   task automatic test_clear_zero();
      for (int a = 0; a < D; a++) begin
         idle();
         R_en = 2'b11;
         R_addr = {AW'(D - 1 - a), AW'(a)};
         tick();
         for (int p = 0; p < NR; p++) begin
            checks++;
            if (rv1[p] !== 1'b1 || rd1[p*W +: W] !== '0) begin
               errors++;
               $display("FAIL zero1 a=%0d p=%0d: got v=%b d=%h want 1 0",
                        a, p, rv1[p], rd1[p*W +: W]);
            end
            checks++;
            if (rv0[p] !== 1'b1 || rd0[p*W +: W] !== '0) begin
               errors++;
               $display("FAIL zero0 a=%0d p=%0d: got v=%b d=%h want 1 0",
                        a, p, rv0[p], rd0[p*W +: W]);
            end
         end
      end
   endtask

   task automatic test_mask();
      logic [W-1:0] want;
      want = '1;
      want[7:0] = 8'h00;
      idle();
      W_en = 1; W_addr = 5; W_mask = '1; W_data = '1;
      tick();
      W_data = '0; W_mask = 30'h1;
      tick();
      idle();
      R_en = 2'b01; R_addr = {AW'(0), AW'(5)};
      tick();
      checks++;
      if (rd1[W-1:0] !== want || rv1[0] !== 1'b1) begin
         errors++;
         $display("FAIL mask1: got %h want %h", rd1[W-1:0], want);
      end
      checks++;
      if (rd0[W-1:0] !== want) begin
         errors++;
         $display("FAIL mask0: got %h want %h", rd0[W-1:0], want);
      end
      checks++;
      if (rd1[W-1:0] !== exp_d1[0]) begin
         errors++;
         $display("FAIL mask_model: got %h want %h", rd1[W-1:0], exp_d1[0]);
      end
   endtask

   task automatic test_bypass();
      logic [W-1:0] prior;
      logic [W-1:0] a5;
      prior = rnd240();
      a5 = {30{8'hA5}};
      idle();
      W_en = 1; W_addr = 7; W_mask = '1; W_data = prior;
      tick();
      W_data = a5;
      R_en = 2'b11; R_addr = {AW'(7), AW'(7)};
      tick();
      for (int p = 0; p < NR; p++) begin
         checks++;
         if (rd1[p*W +: W] !== a5) begin
            errors++;
            $display("FAIL byp1 p=%0d: got %h want %h", p, rd1[p*W +: W], a5);
         end
         checks++;
         if (rd0[p*W +: W] !== prior) begin
            errors++;
            $display("FAIL byp0 p=%0d: got %h want %h",
                     p, rd0[p*W +: W], prior);
         end
      end
      // partial-mask forwarding
      W_mask = 30'($urandom);
      W_data = rnd240();
      R_en = 2'b01;
      tick();
      checks++;
      if (rd1[W-1:0] !== exp_d1[0]) begin
         errors++;
         $display("FAIL byp_part1: got %h want %h", rd1[W-1:0], exp_d1[0]);
      end
      checks++;
      if (rd0[W-1:0] !== a5) begin
         errors++;
         $display("FAIL byp_part0: got %h want %h", rd0[W-1:0], a5);
      end
   endtask

   task automatic test_oob();
      idle();
      R_en = 2'b11; R_addr = {AW'(45), AW'(3)};
      tick();
      checks++;
      if (rv1 !== 2'b01 || rv0 !== 2'b01) begin
         errors++;
         $display("FAIL oob_valid: got %b/%b want 01", rv1, rv0);
      end
      checks++;
      if (rd1[W-1:0] !== model[3] || rd1[W +: W] !== exp_d1[1]) begin
         errors++;
         $display("FAIL oob_data: got %h want %h", rd1[W +: W], exp_d1[1]);
      end
      checks++;
      if (err1 !== 1'b1 || err0 !== 1'b1) begin
         errors++;
         $display("FAIL oob_err: got %b/%b want 1", err1, err0);
      end
      idle();
      tick();
      checks++;
      if (err1 !== 1'b0) begin
         errors++;
         $display("FAIL oob_pulse: got %b want 0", err1);
      end
      W_en = 1; W_addr = 50; W_mask = '1; W_data = '1;
      tick();
      checks++;
      if (err1 !== 1'b1 || err0 !== 1'b1) begin
         errors++;
         $display("FAIL oob_werr: got %b/%b want 1", err1, err0);
      end
   endtask

   task automatic test_flush();
      int n;
      idle();
      tick();
      flush = 1;
      W_en = 1; W_addr = 2; W_mask = '1; W_data = '1;
      R_en = 2'b01; R_addr = {AW'(0), AW'(5)};
      tick();
      checks++;
      if (rv1[0] !== 1'b1 || rd1[W-1:0] !== exp_d1[0]
          || rd0[W-1:0] !== exp_d0[0]) begin
         errors++;
         $display("FAIL flush_read: got %h want %h", rd1[W-1:0], exp_d1[0]);
      end
      n = 0;
      while (busy1 && n < 100) begin
         n++;
         W_en = 1; W_addr = AW'($urandom_range(0, D - 1));
         W_mask = '1; W_data = rnd240();
         flush = $urandom_range(0, 1) == 1;
         R_en = 2'b11;
         tick();
         checks++;
         if (rv1 !== '0 || err1 !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy_io: got v=%b e=%b want 00 0", rv1, err1);
         end
      end
      checks++;
      if (n !== D) begin
         errors++;
         $display("FAIL flush_busy_len: got %0d want %0d", n, D);
      end
      for (int a = 0; a < D; a++) begin
         idle();
         R_en = 2'b10; R_addr = {AW'(a), AW'(0)};
         tick();
         checks++;
         if (rv1[1] !== 1'b1 || rd1[W +: W] !== '0 || rd0[W +: W] !== '0) begin
            errors++;
            $display("FAIL flush_zero a=%0d: got %h want 0", a, rd1[W +: W]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int n;
      idle();
      flush = 1;
      tick();
      idle();
      repeat (20) tick();
      do_reset();
      n = 0;
      while (busy1 && n < 100) begin
         n++;
         tick();
      end
      checks++;
      if (n !== D) begin
         errors++;
         $display("FAIL mid_reset_len: got %0d want %0d", n, D);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         R_en = NR'($urandom_range(0, 3));
         R_addr = {pick(), pick()};
         W_en = $urandom_range(0, 1) == 1;
         W_addr = pick();
         W_mask = 30'($urandom);
         W_data = rnd240();
         flush = $urandom_range(0, 99) == 0;
         tick();
         for (int p = 0; p < NR; p++) begin
            checks++;
            if (rv1[p] !== exp_v[p] || rv0[p] !== exp_v[p]) begin
               errors++;
               $display("FAIL rnd_v c=%0d p=%0d: got %b/%b want %b",
                        c, p, rv1[p], rv0[p], exp_v[p]);
            end
            checks++;
            if (rd1[p*W +: W] !== exp_d1[p]) begin
               errors++;
               $display("FAIL rnd_d1 c=%0d p=%0d: got %h want %h",
                        c, p, rd1[p*W +: W], exp_d1[p]);
            end
            checks++;
            if (rd0[p*W +: W] !== exp_d0[p]) begin
               errors++;
               $display("FAIL rnd_d0 c=%0d p=%0d: got %h want %h",
                        c, p, rd0[p*W +: W], exp_d0[p]);
            end
         end
         checks++;
         if (err1 !== exp_err || err0 !== exp_err) begin
            errors++;
            $display("FAIL rnd_err c=%0d: got %b/%b want %b",
                     c, err1, err0, exp_err);
         end
         checks++;
         if (busy1 !== exp_busy || busy0 !== exp_busy) begin
            errors++;
            $display("FAIL rnd_busy c=%0d: got %b/%b want %b",
                     c, busy1, busy0, exp_busy);
         end
      end
   endtask

   initial begin
      reset = 0;
      idle();
      #2;
      test_reset();
      test_clear_zero();
      test_mask();
      test_bypass();
      test_oob();
      test_flush();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
